// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_sync_gen
// Brief   : VGA 640x480@60 timing from a pixel-rate enable on the system clock.
//           Macro VGA_SYNC_PIPE_EN adds a second output register stage.
// Rev     : 1.0
// ============================================================================
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] c_h_last = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_v_last = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_h_act  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_v_act  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_hs_beg = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] c_hs_end = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] c_vs_beg = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] c_vs_end = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
  logic [CNT_W-1:0] r_x1, r_y1;
  logic             r_hs1, r_vs1, r_vid1;
  logic             r_ls, r_fs;
  logic             w_vid, w_hs, w_vs, w_sol, w_sof;
  logic             w_sol_src, w_sof_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (pix_en) begin
      if (r_h_cnt == c_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  // Decode from the pre-increment counts; the register stages supply latency.
  assign w_vid = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
  assign w_hs  = !((r_h_cnt >= c_hs_beg) && (r_h_cnt < c_hs_end));
  assign w_vs  = !((r_v_cnt >= c_vs_beg) && (r_v_cnt < c_vs_end));
  assign w_sol = (r_h_cnt == '0);
  assign w_sof = w_sol && (r_v_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x1   <= '0;
      r_y1   <= '0;
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_vid1 <= 1'b0;
    end else if (pix_en) begin
      r_x1   <= r_h_cnt;
      r_y1   <= r_v_cnt;
      r_hs1  <= w_hs;
      r_vs1  <= w_vs;
      r_vid1 <= w_vid;
    end
  end

`ifdef VGA_SYNC_PIPE_EN
  logic [CNT_W-1:0] r_x2, r_y2;
  logic             r_hs2, r_vs2, r_vid2;
  logic             r_sol1, r_sof1;

  // Start flags travel with stage 1 as levels; only the last stage emits pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sol1 <= 1'b0;
      r_sof1 <= 1'b0;
      r_x2   <= '0;
      r_y2   <= '0;
      r_hs2  <= 1'b1;
      r_vs2  <= 1'b1;
      r_vid2 <= 1'b0;
    end else if (pix_en) begin
      r_sol1 <= w_sol;
      r_sof1 <= w_sof;
      r_x2   <= r_x1;
      r_y2   <= r_y1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_vid2 <= r_vid1;
    end
  end

  assign w_sol_src = r_sol1;
  assign w_sof_src = r_sof1;
  assign x         = r_x2;
  assign y         = r_y2;
  assign hsync     = r_hs2;
  assign vsync     = r_vs2;
  assign video_on  = r_vid2;
`else
  assign w_sol_src = w_sol;
  assign w_sof_src = w_sof;
  assign x         = r_x1;
  assign y         = r_y1;
  assign hsync     = r_hs1;
  assign vsync     = r_vs1;
  assign video_on  = r_vid1;
`endif

  // Pulses clear on any non-enable clk so they are exactly one clk wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end else begin
      r_ls <= pix_en & w_sol_src;
      r_fs <= pix_en & w_sof_src;
    end
  end

  assign line_start  = r_ls;
  assign frame_start = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for vga_sync_gen: full-size instance for line/stall/reset,
// a shrunken-geometry instance so whole frames fit in a short run.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic       pix_en;
  int         mode;   // 0 toggle, 1 stuck high, 2 stuck low
  int         checks = 0;
  int         errors = 0;
  int         stray  = 0;

  logic       hs, vs, von, ls, fs;
  logic [9:0] x, y;
  logic       s_hs, s_vs, s_von, s_ls, s_fs;
  logic [9:0] s_x, s_y;

  vga_sync_gen u_dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(hs), .vsync(vs), .video_on(von), .x(x), .y(y),
    .line_start(ls), .frame_start(fs)
  );

  // 16 px/line (active 8, sync 10..12), 10 lines/frame (active 4, vsync 6..7)
  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2), .CNT_W(10)
  ) u_small (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_von), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    pix_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       pix_en = ~pix_en;
        1:       pix_en = 1'b1;
        default: pix_en = 1'b0;
      endcase
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Returns at the negedge following the next pixel-tick load.
  task automatic next_load();
    int n = 0;
    while (pix_en !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
      if (ls !== 1'b0 || fs !== 1'b0) stray++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL next_load: no pixel tick for %0d clk, required a tick", n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    mode = 2;
    rst  = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (x !== 10'd0 || y !== 10'd0) begin
      errors++; $display("FAIL reset_xy: got x=%0d y=%0d, want 0 0", x, y);
    end
    checks++;
    if (hs !== 1'b1 || vs !== 1'b1 || von !== 1'b0) begin
      errors++; $display("FAIL reset_sync: got hs=%b vs=%b von=%b, want 1 1 0", hs, vs, von);
    end
    checks++;
    if (ls !== 1'b0 || fs !== 1'b0) begin
      errors++; $display("FAIL reset_pulse: got ls=%b fs=%b, want 0 0", ls, fs);
    end
    rst  = 1'b0;
    mode = 0;
    repeat (LAT) next_load();
    checks++;
    if (x !== 10'd0 || y !== 10'd0 || von !== 1'b1 || hs !== 1'b1 || vs !== 1'b1) begin
      errors++;
      $display("FAIL first_load: got x=%0d y=%0d von=%b hs=%b vs=%b, want 0 0 1 1 1", x, y, von, hs, vs);
    end
    checks++;
    if (ls !== 1'b1 || fs !== 1'b1) begin
      errors++; $display("FAIL first_pulse: got ls=%b fs=%b, want 1 1", ls, fs);
    end
    @(negedge clk);
    checks++;
    if (ls !== 1'b0 || fs !== 1'b0 || x !== 10'd0) begin
      errors++; $display("FAIL pulse_width: got ls=%b fs=%b x=%0d, want 0 0 0", ls, fs, x);
    end
  endtask

  task automatic test_line();
    int   hs_low  = 0;
    int   first_hs = -1;
    int   von_cnt = 0;
    int   last_x  = -1;
    int   bad_seq = 0;
    logic von639  = 1'bx;
    logic von640  = 1'bx;
    stray = 0;
    for (int i = 0; i < 800; i++) begin
      if (x !== 10'(i) || y !== 10'd0) bad_seq++;
      if (hs === 1'b0) begin
        hs_low++;
        if (first_hs < 0) first_hs = int'(x);
      end
      if (von === 1'b1) von_cnt++;
      if (i == 639) von639 = von;
      if (i == 640) von640 = von;
      last_x = int'(x);
      next_load();
    end
    checks++;
    if (bad_seq !== 0) begin
      errors++; $display("FAIL line_seq: got %0d out-of-order samples, want 0", bad_seq);
    end
    checks++;
    if (hs_low !== 96) begin
      errors++; $display("FAIL hsync_width: got %0d ticks, want 96", hs_low);
    end
    checks++;
    if (first_hs !== 656) begin
      errors++; $display("FAIL hsync_start: got x=%0d, want 656", first_hs);
    end
    checks++;
    if (von_cnt !== 640 || von639 !== 1'b1 || von640 !== 1'b0) begin
      errors++;
      $display("FAIL video_on: got count=%0d x639=%b x640=%b, want 640 1 0", von_cnt, von639, von640);
    end
    checks++;
    if (last_x !== 799 || x !== 10'd0 || y !== 10'd1) begin
      errors++; $display("FAIL line_wrap: got last=%0d x=%0d y=%0d, want 799 0 1", last_x, x, y);
    end
    checks++;
    if (ls !== 1'b1 || fs !== 1'b0) begin
      errors++; $display("FAIL line_pulse: got ls=%b fs=%b, want 1 0", ls, fs);
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL stray_pulse: got %0d pulses on idle clk, want 0", stray);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    while (x !== 10'd300 && n < 1000) begin
      next_load();
      n++;
    end
    checks++;
    if (x !== 10'd300 || y !== 10'd1) begin
      errors++; $display("FAIL stall_reach: got x=%0d y=%0d, want 300 1", x, y);
    end
    mode = 2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({x, y, hs, vs, von, ls, fs} !== {10'd300, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold: cyc %0d got x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b, want 300 1 1 1 1 0 0",
                 i, x, y, hs, vs, von, ls, fs);
      end
    end
    mode = 0;
    next_load();
    checks++;
    if (x !== 10'd301 || y !== 10'd1) begin
      errors++; $display("FAIL stall_resume: got x=%0d y=%0d, want 301 1", x, y);
    end
  endtask

  task automatic test_stuck_high();
    mode = 1;
    for (int k = 1; k <= 5; k++) begin
      next_load();
      checks++;
      if (x !== 10'(301 + k) || ls !== 1'b0) begin
        errors++; $display("FAIL stuck_high: got x=%0d ls=%b, want %0d 0", x, ls, 301 + k);
      end
    end
    checks++;
    if (pix_en !== 1'b1) begin
      errors++; $display("FAIL stuck_high_en: got pix_en=%b, want 1", pix_en);
    end
    mode = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (x !== 10'd700 && n < 1000) begin
      next_load();
      n++;
    end
    checks++;
    if (x !== 10'd700 || y !== 10'd1 || hs !== 1'b0) begin
      errors++; $display("FAIL rmid_reach: got x=%0d y=%0d hs=%b, want 700 1 0", x, y, hs);
    end
    rst = 1'b1;
    #2;
    checks++;
    if ({x, y, hs, vs, von, ls, fs} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rmid_async: got x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b, want 0 0 1 1 0 0 0",
               x, y, hs, vs, von, ls, fs);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (LAT) next_load();
    checks++;
    if (x !== 10'd0 || y !== 10'd0 || von !== 1'b1 || ls !== 1'b1 || fs !== 1'b1) begin
      errors++;
      $display("FAIL rmid_restart: got x=%0d y=%0d von=%b ls=%b fs=%b, want 0 0 1 1 1", x, y, von, ls, fs);
    end
  endtask

  task automatic test_frame();
    int nfs = 0, t0 = 0, period = 0, lsn = 0;
    int vs_clk = 0, hs_clk = 0, von_clk = 0, ymin = 999, ymax = -1;
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    mode = 0;
    for (int t = 0; t < 1500 && nfs < 2; t++) begin
      @(negedge clk);
      if (s_fs === 1'b1) begin
        nfs++;
        if (nfs == 1) begin
          t0 = t;
          checks++;
          if (s_x !== 10'd0 || s_y !== 10'd0 || s_ls !== 1'b1) begin
            errors++; $display("FAIL frame_first: got x=%0d y=%0d ls=%b, want 0 0 1", s_x, s_y, s_ls);
          end
        end else begin
          period = t - t0;
        end
      end
      if (nfs == 1) begin
        if (s_ls === 1'b1) lsn++;
        if (s_hs === 1'b0) hs_clk++;
        if (s_von === 1'b1) von_clk++;
        if (s_vs === 1'b0) begin
          vs_clk++;
          if (int'(s_y) < ymin) ymin = int'(s_y);
          if (int'(s_y) > ymax) ymax = int'(s_y);
        end
      end
    end
    checks++;
    if (nfs !== 2 || period !== 320) begin
      errors++; $display("FAIL frame_period: got %0d starts period=%0d clk, want 2 320", nfs, period);
    end
    checks++;
    if (lsn !== 10) begin
      errors++; $display("FAIL frame_lines: got %0d line_start, want 10", lsn);
    end
    checks++;
    if (vs_clk !== 64 || ymin !== 6 || ymax !== 7) begin
      errors++; $display("FAIL vsync_lines: got %0d clk y=%0d..%0d, want 64 6..7", vs_clk, ymin, ymax);
    end
    checks++;
    if (hs_clk !== 60 || von_clk !== 64) begin
      errors++; $display("FAIL frame_counts: got hs_low=%0d von=%0d clk, want 60 64", hs_clk, von_clk);
    end
  endtask

  initial begin
    rst  = 1'b1;
    mode = 2;
    test_reset();
    test_line();
    test_stall();
    test_stuck_high();
    test_reset_mid();
    test_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA 640x480@60 Hz horizontal/vertical timing for the VGA display path.
- Sits directly downstream of the 50 MHz to 25 MHz clock divider. The divider's output is consumed as a pixel-rate enable (pix_en); it is not used as a clock.
- All logic runs on the 50 MHz system clock.
- Produces sync pulses, an active-video flag, pixel coordinates and frame/line markers for the pixel generator.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CNT_W, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel-rate enable from divider; high every other clk
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high while the current pixel is in the visible area
- x  out  CNT_W  current horizontal count
- y  out  CNT_W  current vertical count
- line_start  out  1  one-clk pulse at the start of each line
- frame_start  out  1  one-clk pulse at the start of each frame

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Reset (async, rst=1), applied to all state immediately:
  - h_cnt=0, v_cnt=0
  - hsync=1, vsync=1, video_on=0, x=0, y=0, line_start=0, frame_start=0
- Counters advance only on clk edges where pix_en=1; otherwise all state holds.
  - h_cnt: counts 0..H_TOTAL-1; at H_TOTAL-1 it wraps to 0 and v_cnt advances.
  - v_cnt: counts 0..V_TOTAL-1; at V_TOTAL-1 with h wrap it wraps to 0.
- Output register stage: loaded on pix_en=1 from the pre-increment counter values, giving 1 pix_en tick of latency. All outputs are mutually aligned.
  - x = h_cnt, y = v_cnt (raw counts, including blanking)
  - video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hsync = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vsync = 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491)
- line_start: 1 for exactly one clk (the clk after the load) when the loaded h_cnt=0; 0 otherwise. It does not stay high across the non-enable clk.
- frame_start: same as line_start but requires loaded h_cnt=0 and v_cnt=0; it coincides with that line_start.
- pix_en stuck high: counters advance every clk. Timing stays correct relative to pix_en; the absolute rate is then doubled.
- pix_en stuck low: everything freezes; pulses stay 0.
- Reset mid-frame: counters and outputs return to reset values at once. The first pix_en after release loads outputs for (0,0) and raises line_start and frame_start.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: VGA_SYNC_PIPE_EN.
- Defined: adds a second output register stage, also enabled by pix_en, after the first. It gives 2 pix_en ticks of latency, to align with a one-cycle pixel-RAM read. Pulses remain 1 clk wide. Reset values are the same as in Behaviour.
- Undefined: single stage as described in Behaviour.

Test Plan:
- rst high, then low with pix_en toggling every clk -> first pix_en loads x=0, y=0, video_on=1, hsync=1, vsync=1. Same clk after that load: line_start=1 and frame_start=1, each for one clk.
- Run one line -> hsync low for exactly 96 pix_en ticks, starting when x=656; video_on=0 from x=640 to 799; x wraps 799->0 and y increments.
- Run full frame -> vsync low for exactly 2 lines (y=490,491); frame_start period = 800*525*2 = 840000 clk; line_start count per frame = 525.
- Hold pix_en=0 for 20 clk mid-line (x=300) -> x, y and syncs unchanged; no pulses; resumes at x=301.
- Assert rst at x=700, y=200 -> outputs go to reset values asynchronously, before the next clk edge; after release, timing restarts at (0,0).
- Compile with VGA_SYNC_PIPE_EN -> same sequences as above, each delayed by one extra pix_en tick (2 clk).
